// File: rtl/commit_trace_ctrl_pkg.sv
// rtl/commit_trace_ctrl_pkg.sv - shared types and constants for the commit trace controller
package commit_trace_ctrl_pkg;

    localparam int XLEN = 64;
    localparam int ILEN = 32;

    // Controller life cycle: normal tracing, draining after ebreak, and the two terminal states
    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HALT  = 2'd2,
        ST_HANG  = 2'd3
    } state_e;

    // One committed instruction as it travels through the trace FIFO
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] dnpc;
        logic [ILEN-1:0] inst;
        logic            skip;
    } entry_t;

    localparam int ENTRY_W = $bits(entry_t);

endpackage

// File: rtl/commit_trace_ctrl_if.sv
// rtl/commit_trace_ctrl_if.sv - commit-side and sink-side handshake bundle
interface commit_trace_ctrl_if;
    import commit_trace_ctrl_pkg::*;

    // Commit side (core -> controller)
    logic            cmt_valid;
    logic            cmt_ready;
    logic [XLEN-1:0] cmt_pc;
    logic [XLEN-1:0] cmt_dnpc;
    logic [ILEN-1:0] cmt_inst;
    logic            cmt_skip;
    logic            cmt_break;
    logic [XLEN-1:0] cmt_a0;

    // Sink side (controller -> trace sink)
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_dnpc;
    logic [ILEN-1:0] out_inst;
    logic            out_skip;

    // Core plus sink side of the bundle
    modport master (
        output cmt_valid, cmt_pc, cmt_dnpc, cmt_inst, cmt_skip, cmt_break, cmt_a0,
        output out_ready,
        input  cmt_ready,
        input  out_valid, out_pc, out_dnpc, out_inst, out_skip
    );

    // Controller side of the bundle
    modport slave (
        input  cmt_valid, cmt_pc, cmt_dnpc, cmt_inst, cmt_skip, cmt_break, cmt_a0,
        input  out_ready,
        output cmt_ready,
        output out_valid, out_pc, out_dnpc, out_inst, out_skip
    );

endinterface

// File: rtl/trace_fifo.sv
// rtl/trace_fifo.sv - registered commit FIFO without fall-through
module trace_fifo #(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 8,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    // A push into a full FIFO is dropped even when a pop frees a slot the same cycle
    assign full     = (count_q == CNT_W'(DEPTH));
    assign empty    = (count_q == '0);
    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;
    assign pop_data = mem_q[rd_ptr_q];

    // Next pointers and occupancy; pointers wrap naturally since DEPTH is a power of two
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy state; reset discards every queued entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage is left unreset; its contents only matter while the FIFO is non-empty
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/commit_trace_ctrl.sv
// rtl/commit_trace_ctrl.sv - commit trace FIFO, end-of-simulation FSM, watchdog and counters
module commit_trace_ctrl
    import commit_trace_ctrl_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic                clk,
    input  logic                rst_n,
    commit_trace_ctrl_if.slave  bus,
    output logic                halt,
    output logic                good_trap,
    output logic                hang,
    output logic [63:0]         inst_cnt,
    output logic [63:0]         cycle_cnt
);

    localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    state_e          state_q, state_d;
    logic [WD_W-1:0] wdog_q, wdog_d;
    logic            good_trap_q, good_trap_d;
    logic            halt_q, halt_d;
    logic            hang_q, hang_d;
    logic [63:0]     inst_cnt_q, inst_cnt_d;
    logic [63:0]     cycle_cnt_q, cycle_cnt_d;

    logic            fifo_full;
    logic            fifo_empty;
    logic            cmt_ready;
    logic            accept;
    logic            pop;
    entry_t          push_entry;
    entry_t          head;

    assign cmt_ready = (state_q == ST_RUN) && !fifo_full;
    assign accept    = bus.cmt_valid && cmt_ready;
    assign pop       = !fifo_empty && bus.out_ready;

    assign push_entry.pc   = bus.cmt_pc;
    assign push_entry.dnpc = bus.cmt_dnpc;
    assign push_entry.inst = bus.cmt_inst;
    assign push_entry.skip = bus.cmt_skip;

    trace_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (accept),
        .push_data (push_entry),
        .pop       (pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign bus.cmt_ready = cmt_ready;
    assign bus.out_valid = !fifo_empty;
    assign bus.out_pc    = head.pc;
    assign bus.out_dnpc  = head.dnpc;
    assign bus.out_inst  = head.inst;
    assign bus.out_skip  = head.skip;

    assign halt      = halt_q;
    assign good_trap = good_trap_q;
    assign hang      = hang_q;
    assign inst_cnt  = inst_cnt_q;
    assign cycle_cnt = cycle_cnt_q;

    // Next state: an ebreak accept outranks a watchdog expiry in the same cycle
    always_comb begin
        state_d     = state_q;
        wdog_d      = wdog_q;
        good_trap_d = good_trap_q;
        case (state_q)
            ST_RUN: begin
                if (accept && bus.cmt_break) begin
                    state_d     = ST_DRAIN;
                    good_trap_d = (bus.cmt_a0 == '0);
                    wdog_d      = '0;
                end else if (accept) begin
                    wdog_d = '0;
                end else if (wdog_q == WD_LAST) begin
                    state_d = ST_HANG;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                if (fifo_empty) state_d = ST_HALT;
            end
            default: begin
                state_d = state_q;
            end
        endcase
        halt_d = (state_d == ST_HALT);
        hang_d = (state_d == ST_HANG);
    end

    // Counters: retired instructions count pops; cycles run only until a terminal state
    always_comb begin
        inst_cnt_d  = pop ? inst_cnt_q + 64'd1 : inst_cnt_q;
        cycle_cnt_d = ((state_q == ST_RUN) || (state_q == ST_DRAIN)) ? cycle_cnt_q + 64'd1
                                                                     : cycle_cnt_q;
    end

    // Controller state with registered status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            wdog_q      <= '0;
            good_trap_q <= 1'b0;
            halt_q      <= 1'b0;
            hang_q      <= 1'b0;
            inst_cnt_q  <= '0;
            cycle_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wdog_q      <= wdog_d;
            good_trap_q <= good_trap_d;
            halt_q      <= halt_d;
            hang_q      <= hang_d;
            inst_cnt_q  <= inst_cnt_d;
            cycle_cnt_q <= cycle_cnt_d;
        end
    end

endmodule

// File: tb/tb_commit_trace_ctrl.sv
// tb/tb_commit_trace_ctrl.sv - self-checking bench for commit_trace_ctrl
module tb_commit_trace_ctrl;
    import commit_trace_ctrl_pkg::*;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 40;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        halt;
    logic        good_trap;
    logic        hang;
    logic [63:0] inst_cnt;
    logic [63:0] cycle_cnt;

    commit_trace_ctrl_if bus();

    commit_trace_ctrl #(
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .halt      (halt),
        .good_trap (good_trap),
        .hang      (hang),
        .inst_cnt  (inst_cnt),
        .cycle_cnt (cycle_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;

    task automatic expect_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: a queue of pending entries plus the life-cycle phase
    typedef enum {P_RUN, P_DRAIN, P_HALT, P_HANG} phase_t;
    entry_t      m_q[$];
    phase_t      m_phase;
    int          m_idle;
    bit          m_gt;
    logic [63:0] m_inst;
    logic [63:0] m_cyc;

    function automatic entry_t rand_entry();
        entry_t e;
        e.pc   = {$urandom, $urandom};
        e.dnpc = {$urandom, $urandom};
        e.inst = $urandom;
        e.skip = 1'($urandom_range(0, 1));
        return e;
    endfunction

    function automatic entry_t mk_entry(input logic [63:0] pc);
        entry_t e;
        e.pc   = pc;
        e.dnpc = pc + 64'd4;
        e.inst = $urandom;
        e.skip = 1'b0;
        return e;
    endfunction

    // Called at a falling edge with idle inputs; leaves the bench at a falling edge out of reset
    task automatic do_reset();
        bus.cmt_valid = 1'b0;
        bus.cmt_break = 1'b0;
        bus.cmt_a0    = '0;
        bus.cmt_pc    = '0;
        bus.cmt_dnpc  = '0;
        bus.cmt_inst  = '0;
        bus.cmt_skip  = 1'b0;
        bus.out_ready = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        expect_eq("rst_out_valid", bus.out_valid, 0);
        expect_eq("rst_cmt_ready", bus.cmt_ready, 1);
        expect_eq("rst_halt", halt, 0);
        expect_eq("rst_hang", hang, 0);
        expect_eq("rst_good_trap", good_trap, 0);
        expect_eq("rst_inst_cnt", inst_cnt, 0);
        expect_eq("rst_cycle_cnt", cycle_cnt, 0);
        @(negedge clk);
        rst_n   = 1'b1;
        m_q.delete();
        m_phase = P_RUN;
        m_idle  = 0;
        m_gt    = 1'b0;
        m_inst  = '0;
        m_cyc   = '0;
    endtask

    // One clock cycle: drive, check against the model, advance the model, wait for the next falling edge
    task automatic step(input bit v, input entry_t e, input bit brk, input logic [63:0] a0,
                        input bit ordy, output bit acc);
        bit exp_rdy;
        bit exp_ov;
        bit pop;
        int n;
        bus.cmt_valid = v;
        bus.cmt_pc    = e.pc;
        bus.cmt_dnpc  = e.dnpc;
        bus.cmt_inst  = e.inst;
        bus.cmt_skip  = e.skip;
        bus.cmt_break = brk;
        bus.cmt_a0    = a0;
        bus.out_ready = ordy;
        #1;
        n       = m_q.size();
        exp_rdy = (m_phase == P_RUN) && (n < DEPTH);
        exp_ov  = (n != 0);
        expect_eq("cmt_ready", bus.cmt_ready, exp_rdy);
        expect_eq("out_valid", bus.out_valid, exp_ov);
        if (exp_ov) begin
            expect_eq("out_pc", bus.out_pc, m_q[0].pc);
            expect_eq("out_dnpc", bus.out_dnpc, m_q[0].dnpc);
            expect_eq("out_inst", bus.out_inst, m_q[0].inst);
            expect_eq("out_skip", bus.out_skip, m_q[0].skip);
        end
        expect_eq("halt", halt, m_phase == P_HALT);
        expect_eq("hang", hang, m_phase == P_HANG);
        expect_eq("good_trap", good_trap, m_gt);
        expect_eq("inst_cnt", inst_cnt, m_inst);
        expect_eq("cycle_cnt", cycle_cnt, m_cyc);
        acc = v && exp_rdy;
        pop = exp_ov && ordy;
        if (m_phase == P_RUN || m_phase == P_DRAIN) m_cyc++;
        case (m_phase)
            P_RUN: begin
                if (acc && brk) begin
                    m_phase = P_DRAIN;
                    m_gt    = (a0 == 0);
                end else if (acc) begin
                    m_idle = 0;
                end else if (m_idle == TIMEOUT - 1) begin
                    m_phase = P_HANG;
                end else begin
                    m_idle++;
                end
            end
            P_DRAIN: if (n == 0) m_phase = P_HALT;
            default: ;
        endcase
        if (pop) begin
            void'(m_q.pop_front());
            m_inst++;
        end
        if (acc) m_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle(input int cycles, input bit ordy);
        bit acc;
        for (int i = 0; i < cycles; i++) step(1'b0, rand_entry(), 1'b0, '0, ordy, acc);
    endtask

    initial begin
        bit     acc;
        int     guard;
        entry_t e5;

        do_reset();

        // Three back-to-back commits drain in order
        for (int i = 0; i < 3; i++) step(1'b1, mk_entry(64'h8000_0000 + 64'(4 * i)), 1'b0, '0, 1'b1, acc);
        idle(3, 1'b1);
        expect_eq("b2b_inst_cnt", inst_cnt, 3);

        // Backpressure: four fill the FIFO, the fifth waits for room
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, rand_entry(), 1'b0, '0, 1'b0, acc);
        #1 expect_eq("full_cmt_ready", bus.cmt_ready, 0);
        e5 = rand_entry();
        step(1'b1, e5, 1'b0, '0, 1'b0, acc);
        guard = 0;
        do begin
            step(1'b1, e5, 1'b0, '0, 1'b1, acc);
            guard++;
        end while (!acc && guard < 10);
        expect_eq("fifth_accept_cycle", guard, 2);
        idle(6, 1'b1);
        expect_eq("full_inst_cnt", inst_cnt, 5);

        // ebreak with a0 = 0 behind two queued entries
        do_reset();
        step(1'b1, rand_entry(), 1'b0, '0, 1'b0, acc);
        step(1'b1, rand_entry(), 1'b0, '0, 1'b0, acc);
        step(1'b1, rand_entry(), 1'b1, 64'd0, 1'b0, acc);
        #1 expect_eq("drain_cmt_ready", bus.cmt_ready, 0);
        guard = 0;
        while (!halt && guard < 20) begin
            step(1'b1, rand_entry(), 1'b0, '0, 1'b1, acc);
            guard++;
        end
        expect_eq("good_halt", halt, 1);
        expect_eq("good_trap_set", good_trap, 1);
        expect_eq("good_inst_cnt", inst_cnt, 3);
        expect_eq("good_cycle_cnt", cycle_cnt, 7);
        idle(5, 1'b1);
        expect_eq("cycle_frozen", cycle_cnt, 7);

        // ebreak with a0 != 0 is a bad trap
        do_reset();
        step(1'b1, rand_entry(), 1'b1, 64'd1, 1'b1, acc);
        guard = 0;
        while (!halt && guard < 10) begin
            idle(1, 1'b1);
            guard++;
        end
        expect_eq("bad_halt", halt, 1);
        expect_eq("bad_trap_clear", good_trap, 0);

        // Watchdog: hang appears exactly after TIMEOUT idle cycles
        do_reset();
        idle(TIMEOUT - 1, 1'b1);
        #1 expect_eq("hang_early", hang, 0);
        idle(1, 1'b1);
        #1 expect_eq("hang_at_timeout", hang, 1);

        // A commit in the last watchdog cycle keeps the controller running
        do_reset();
        idle(TIMEOUT - 1, 1'b1);
        step(1'b1, rand_entry(), 1'b0, '0, 1'b1, acc);
        idle(5, 1'b1);
        expect_eq("hang_prevented", hang, 0);

        // Reset mid-operation discards queued entries immediately
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b1, rand_entry(), 1'b0, '0, 1'b0, acc);
        do_reset();
        idle(2, 1'b1);

        // Randomized runs, alternating busy traffic and sparse traffic that tends to hang
        for (int run = 0; run < 6; run++) begin
            int pv;
            pv = (run % 2 == 0) ? 60 : 3;
            do_reset();
            for (int c = 0; c < 300; c++) begin
                bit          v;
                bit          brk;
                bit          ordy;
                logic [63:0] a0;
                v    = ($urandom_range(0, 99) < pv);
                brk  = ($urandom_range(0, 39) == 0);
                a0   = $urandom_range(0, 1) ? 64'd0 : {$urandom, $urandom};
                ordy = ($urandom_range(0, 99) < 50);
                step(v, rand_entry(), brk, a0, ordy, acc);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
